// File: rtl/cacheline_adapter_if.sv
// Handshake bundle joining the cache dfp port, the line adapter and the banked memory bus.
interface cacheline_adapter_if #(
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
);
  logic [31:0]          dfp_addr;
  logic                 dfp_read;
  logic                 dfp_write;
  logic [LINE_BITS-1:0] dfp_wdata;
  logic [LINE_BITS-1:0] dfp_rdata;
  logic                 dfp_resp;
  logic [31:0]          bmem_addr;
  logic                 bmem_read;
  logic                 bmem_write;
  logic [BEAT_BITS-1:0] bmem_wdata;
  logic                 bmem_ready;
  logic [BEAT_BITS-1:0] bmem_rdata;
  logic                 bmem_rvalid;

  // master: the adapter, answering the cache and driving the memory burst
  modport master (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  bmem_ready, bmem_rdata, bmem_rvalid,
    output dfp_rdata, dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata
  );

  modport slave (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output bmem_ready, bmem_rdata, bmem_rvalid,
    input  dfp_rdata, dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Splits 256-bit cache line reads/writes into 4-beat 64-bit memory bursts and back.
// Define CLADAPT_PERF_CNT_EN to add the perf_rd_lines/perf_wr_lines/perf_stall_cycles counters.
module cacheline_adapter #(
  parameter int LINE_BITS   = 256,
  parameter int BEAT_BITS   = 64,
  parameter int BEATS       = 4,
  parameter int OFFSET_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
`ifdef CLADAPT_PERF_CNT_EN
  output logic [31:0]         perf_rd_lines,
  output logic [31:0]         perf_wr_lines,
  output logic [31:0]         perf_stall_cycles,
`endif
  cacheline_adapter_if.master bus
);

  localparam int CNT_BITS = $clog2(BEATS);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, DONE} state_t;

  state_t                          state;
  logic [CNT_BITS-1:0]             cnt;
  logic [BEATS-1:0][BEAT_BITS-1:0] line_buf;
  logic [BEATS-1:0][BEAT_BITS-1:0] rd_line;
  logic                            rd_last;
  logic                            wr_last;

  // The final read beat goes straight into dfp_rdata, so the previous line stays visible until then.
  always_comb begin
    rd_line      = line_buf;
    rd_line[cnt] = bus.bmem_rdata;
  end

  // A write burst is over once the counter has wrapped back to 0 with bmem_write still up.
  assign rd_last = (state == RD_DATA) && bus.bmem_rvalid && (cnt == CNT_BITS'(BEATS - 1));
  assign wr_last = (state == WR_DATA) && bus.bmem_write && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      line_buf       <= '0;
      bus.dfp_rdata  <= '0;
      bus.dfp_resp   <= 1'b0;
      bus.bmem_addr  <= '0;
      bus.bmem_read  <= 1'b0;
      bus.bmem_write <= 1'b0;
      bus.bmem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dfp_write) begin
            bus.bmem_addr <= {bus.dfp_addr[31:OFFSET_BITS], OFFSET_BITS'(0)};
            line_buf      <= bus.dfp_wdata;
            cnt           <= '0;
            state         <= WR_DATA;
          end else if (bus.dfp_read) begin
            bus.bmem_addr <= {bus.dfp_addr[31:OFFSET_BITS], OFFSET_BITS'(0)};
            bus.bmem_read <= 1'b1;
            state         <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (bus.bmem_ready) begin
            bus.bmem_read <= 1'b0;
            cnt           <= '0;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (bus.bmem_rvalid) begin
            line_buf[cnt] <= bus.bmem_rdata;
            cnt           <= cnt + 1'b1;
          end
          if (rd_last) begin
            bus.dfp_rdata <= LINE_BITS'(rd_line);
            bus.dfp_resp  <= 1'b1;
            state         <= DONE;
          end
        end
        WR_DATA: begin
          if (wr_last) begin
            bus.bmem_write <= 1'b0;
            bus.dfp_resp   <= 1'b1;
            state          <= DONE;
          end else if (bus.bmem_write || bus.bmem_ready) begin
            bus.bmem_write <= 1'b1;
            bus.bmem_wdata <= line_buf[cnt];
            cnt            <= cnt + 1'b1;
          end
        end
        DONE: begin
          bus.dfp_resp <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CLADAPT_PERF_CNT_EN
  logic burst_wait;

  assign burst_wait = ((state == RD_REQ) || ((state == WR_DATA) && !bus.bmem_write)) && !bus.bmem_ready;

  // Line counters step on the edge entering DONE so the new value is visible during the resp cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_lines     <= '0;
      perf_wr_lines     <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (rd_last)    perf_rd_lines     <= perf_rd_lines + 32'd1;
      if (wr_last)    perf_wr_lines     <= perf_wr_lines + 32'd1;
      if (burst_wait) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
